// File: rtl/id_stage_pipelined.sv
// Instruction-decode stage: register file with write-through bypass, immediate
// extender, load-use hazard detection and a registered ID/EX boundary.
module id_stage_pipelined #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 3,
    parameter int IMM_W    = 8,
    parameter int FUNCT_W  = 3,
    parameter int ZERO_REG = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               id_valid,
    input  logic [REG_AW-1:0]  rs,
    input  logic [REG_AW-1:0]  rt,
    input  logic [REG_AW-1:0]  rd,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [IMM_W-1:0]   imm,
    input  logic               ext_zero,
    input  logic [DATA_W-1:0]  pc4_in,
    input  logic               c_reg_write,
    input  logic               c_mem_read,
    input  logic               c_dst_rt,
    input  logic               wb_we,
    input  logic [REG_AW-1:0]  wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               ex_hold,
    input  logic               flush,
    output logic               stall_out,
    output logic               ex_valid,
    output logic [DATA_W-1:0]  ex_rdata1,
    output logic [DATA_W-1:0]  ex_rdata2,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [DATA_W-1:0]  ex_pc4,
    output logic [REG_AW-1:0]  ex_rs,
    output logic [REG_AW-1:0]  ex_rt,
    output logic [REG_AW-1:0]  ex_dest,
    output logic [FUNCT_W-1:0] ex_funct,
    output logic               ex_reg_write,
    output logic               ex_mem_read
);

    localparam int NREG = 2 ** REG_AW;
    localparam bit ZR   = (ZERO_REG != 0);

    function automatic logic is_zero_reg(input logic [REG_AW-1:0] a);
        return ZR && (a == '0);
    endfunction

    // Upper-bit mask collapses to zero when IMM_W >= DATA_W, giving a pass-through.
    function automatic logic [DATA_W-1:0] extend_imm(input logic [IMM_W-1:0] v,
                                                     input logic zero_ext);
        logic [DATA_W-1:0] r;
        logic [DATA_W-1:0] hi_mask;
        r       = DATA_W'(v);
        hi_mask = ~((DATA_W'(1) << IMM_W) - DATA_W'(1));
        if (!zero_ext && v[IMM_W-1]) begin
            r = r | hi_mask;
        end
        return r;
    endfunction

    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] rf_d [NREG];
    logic [DATA_W-1:0] rdata1, rdata2;
    logic [REG_AW-1:0] dest;

    logic               ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0]  ex_rdata1_q, ex_rdata1_d;
    logic [DATA_W-1:0]  ex_rdata2_q, ex_rdata2_d;
    logic [DATA_W-1:0]  ex_imm_q, ex_imm_d;
    logic [DATA_W-1:0]  ex_pc4_q, ex_pc4_d;
    logic [REG_AW-1:0]  ex_rs_q, ex_rs_d;
    logic [REG_AW-1:0]  ex_rt_q, ex_rt_d;
    logic [REG_AW-1:0]  ex_dest_q, ex_dest_d;
    logic [FUNCT_W-1:0] ex_funct_q, ex_funct_d;
    logic               ex_reg_write_q, ex_reg_write_d;
    logic               ex_mem_read_q, ex_mem_read_d;

    always_comb begin
        rf_d = rf_q;
        if (wb_we && !is_zero_reg(wb_addr)) begin
            rf_d[wb_addr] = wb_data;
        end
    end

    // Same-cycle writeback is forwarded so decode never sees a stale value.
    always_comb begin
        rdata1 = rf_q[rs];
        rdata2 = rf_q[rt];
        if (wb_we && (wb_addr == rs)) rdata1 = wb_data;
        if (wb_we && (wb_addr == rt)) rdata2 = wb_data;
        if (is_zero_reg(rs)) rdata1 = '0;
        if (is_zero_reg(rt)) rdata2 = '0;
    end

    assign dest = c_dst_rt ? rt : rd;

    assign stall_out = id_valid & ex_valid_q & ex_mem_read_q
                     & ((ex_dest_q == rs) | (ex_dest_q == rt))
                     & ~is_zero_reg(ex_dest_q);

    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_rdata1_d    = ex_rdata1_q;
        ex_rdata2_d    = ex_rdata2_q;
        ex_imm_d       = ex_imm_q;
        ex_pc4_d       = ex_pc4_q;
        ex_rs_d        = ex_rs_q;
        ex_rt_d        = ex_rt_q;
        ex_dest_d      = ex_dest_q;
        ex_funct_d     = ex_funct_q;
        ex_reg_write_d = ex_reg_write_q;
        ex_mem_read_d  = ex_mem_read_q;
        if (!ex_hold) begin
            if (flush || stall_out || !id_valid) begin
                ex_valid_d     = 1'b0;
                ex_rdata1_d    = '0;
                ex_rdata2_d    = '0;
                ex_imm_d       = '0;
                ex_pc4_d       = '0;
                ex_rs_d        = '0;
                ex_rt_d        = '0;
                ex_dest_d      = '0;
                ex_funct_d     = '0;
                ex_reg_write_d = 1'b0;
                ex_mem_read_d  = 1'b0;
            end else begin
                ex_valid_d     = 1'b1;
                ex_rdata1_d    = rdata1;
                ex_rdata2_d    = rdata2;
                ex_imm_d       = extend_imm(imm, ext_zero);
                ex_pc4_d       = pc4_in;
                ex_rs_d        = rs;
                ex_rt_d        = rt;
                ex_dest_d      = dest;
                ex_funct_d     = funct;
                ex_reg_write_d = c_reg_write;
                ex_mem_read_d  = c_mem_read;
            end
        end
    end

    // ID/EX boundary and register file
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rf_q           <= '{default: '0};
            ex_valid_q     <= 1'b0;
            ex_rdata1_q    <= '0;
            ex_rdata2_q    <= '0;
            ex_imm_q       <= '0;
            ex_pc4_q       <= '0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_dest_q      <= '0;
            ex_funct_q     <= '0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
        end else begin
            rf_q           <= rf_d;
            ex_valid_q     <= ex_valid_d;
            ex_rdata1_q    <= ex_rdata1_d;
            ex_rdata2_q    <= ex_rdata2_d;
            ex_imm_q       <= ex_imm_d;
            ex_pc4_q       <= ex_pc4_d;
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            ex_dest_q      <= ex_dest_d;
            ex_funct_q     <= ex_funct_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_rdata1    = ex_rdata1_q;
    assign ex_rdata2    = ex_rdata2_q;
    assign ex_imm       = ex_imm_q;
    assign ex_pc4       = ex_pc4_q;
    assign ex_rs        = ex_rs_q;
    assign ex_rt        = ex_rt_q;
    assign ex_dest      = ex_dest_q;
    assign ex_funct     = ex_funct_q;
    assign ex_reg_write = ex_reg_write_q;
    assign ex_mem_read  = ex_mem_read_q;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Bench for id_stage_pipelined: directed scenarios plus randomized traffic
// compared against an array-based reference model of the decode stage.
module tb_id_stage_pipelined;

    logic        clock;
    logic        reset_n;
    logic        id_valid;
    logic [2:0]  rs, rt, rd;
    logic [2:0]  funct;
    logic [7:0]  imm;
    logic        ext_zero;
    logic [15:0] pc4_in;
    logic        c_reg_write, c_mem_read, c_dst_rt;
    logic        wb_we;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        ex_hold, flush;
    logic        stall_out;
    logic        ex_valid;
    logic [15:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
    logic [2:0]  ex_rs, ex_rt, ex_dest, ex_funct;
    logic        ex_reg_write, ex_mem_read;

    int n_vec = 0;
    int n_err = 0;

    id_stage_pipelined dut (
        .clock(clock), .reset_n(reset_n), .id_valid(id_valid),
        .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .ext_zero(ext_zero),
        .pc4_in(pc4_in), .c_reg_write(c_reg_write), .c_mem_read(c_mem_read),
        .c_dst_rt(c_dst_rt), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_hold(ex_hold), .flush(flush), .stall_out(stall_out),
        .ex_valid(ex_valid), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
        .ex_imm(ex_imm), .ex_pc4(ex_pc4), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_dest(ex_dest), .ex_funct(ex_funct), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: architectural registers plus the instruction held in EX.
    logic [15:0] regs [8];
    logic        m_valid, m_rw, m_mr;
    logic [15:0] m_rd1, m_rd2, m_imm, m_pc4;
    logic [2:0]  m_rs, m_rt, m_dest, m_funct;

    function automatic logic [15:0] m_read(input logic [2:0] a);
        if (a == 3'd0) return 16'h0000;
        if (wb_we && wb_addr == a) return wb_data;
        return regs[a];
    endfunction

    function automatic logic [15:0] m_ext(input logic [7:0] v, input logic z);
        int s;
        s = $signed(v);
        return z ? {8'h00, v} : s[15:0];
    endfunction

    function automatic logic m_stall();
        return id_valid && m_valid && m_mr && m_dest != 3'd0 &&
               (m_dest == rs || m_dest == rt);
    endfunction

    function automatic logic [78:0] dut_vec();
        return {ex_valid, ex_rdata1, ex_rdata2, ex_imm, ex_pc4, ex_rs, ex_rt,
                ex_dest, ex_funct, ex_reg_write, ex_mem_read};
    endfunction

    function automatic logic [78:0] m_vec();
        return {m_valid, m_rd1, m_rd2, m_imm, m_pc4, m_rs, m_rt,
                m_dest, m_funct, m_rw, m_mr};
    endfunction

    task automatic m_bubble();
        m_valid = 0; m_rw = 0; m_mr = 0;
        m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_pc4 = 0;
        m_rs = 0; m_rt = 0; m_dest = 0; m_funct = 0;
    endtask

    // Advance model and DUT by one rising edge; inputs stay stable throughout.
    task automatic tick();
        logic st;
        logic [15:0] r1, r2;
        st = m_stall();
        r1 = m_read(rs);
        r2 = m_read(rt);
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
            m_bubble();
        end else begin
            if (!ex_hold) begin
                if (flush || st || !id_valid) m_bubble();
                else begin
                    m_valid = 1; m_rd1 = r1; m_rd2 = r2; m_imm = m_ext(imm, ext_zero);
                    m_pc4 = pc4_in; m_rs = rs; m_rt = rt; m_dest = c_dst_rt ? rt : rd;
                    m_funct = funct; m_rw = c_reg_write; m_mr = c_mem_read;
                end
            end
            if (wb_we && wb_addr != 3'd0) regs[wb_addr] = wb_data;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        reset_n = 1; id_valid = 0; rs = 0; rt = 0; rd = 0; funct = 0; imm = 0;
        ext_zero = 0; pc4_in = 0; c_reg_write = 0; c_mem_read = 0; c_dst_rt = 0;
        wb_we = 0; wb_addr = 0; wb_data = 0; ex_hold = 0; flush = 0;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 0;
        tick();
        tick();
        n_vec++;
        if (dut_vec() !== 79'd0) begin
            n_err++; $display("FAIL reset_outputs got=%h want=0", dut_vec());
        end
        reset_n = 1; id_valid = 1; rs = 3; rt = 5;
        #1;
        n_vec++;
        if (stall_out !== 1'b0) begin
            n_err++; $display("FAIL reset_stall got=%b want=0", stall_out);
        end
        tick();
        n_vec++;
        if ({ex_valid, ex_rdata1, ex_rdata2} !== {1'b1, 16'h0, 16'h0}) begin
            n_err++; $display("FAIL reset_first_read got=%b/%h/%h want=1/0000/0000",
                              ex_valid, ex_rdata1, ex_rdata2);
        end
    endtask

    task automatic test_bypass();
        idle();
        id_valid = 1; rs = 3; rt = 1; wb_we = 1; wb_addr = 3; wb_data = 16'hBEEF;
        tick();
        n_vec++;
        if (ex_rdata1 !== 16'hBEEF) begin
            n_err++; $display("FAIL bypass_rs got=%h want=beef", ex_rdata1);
        end
        idle();
        id_valid = 1; rs = 1; rt = 3;
        tick();
        n_vec++;
        if (ex_rdata2 !== 16'hBEEF) begin
            n_err++; $display("FAIL stored_rt got=%h want=beef", ex_rdata2);
        end
        idle();
        id_valid = 1; rs = 0; wb_we = 1; wb_addr = 0; wb_data = 16'h1234;
        tick();
        n_vec++;
        if (ex_rdata1 !== 16'h0000) begin
            n_err++; $display("FAIL zero_bypass got=%h want=0000", ex_rdata1);
        end
        idle();
        id_valid = 1; rs = 0; rt = 0;
        tick();
        n_vec++;
        if ({ex_rdata1, ex_rdata2} !== 32'h0) begin
            n_err++; $display("FAIL zero_stored got=%h/%h want=0000/0000", ex_rdata1, ex_rdata2);
        end
    endtask

    task automatic test_extension();
        logic [7:0]  imms [3] = '{8'hF0, 8'hF0, 8'h7F};
        logic        zs   [3] = '{1'b0, 1'b1, 1'b0};
        logic [15:0] want [3] = '{16'hFFF0, 16'h00F0, 16'h007F};
        for (int i = 0; i < 3; i++) begin
            idle();
            id_valid = 1; imm = imms[i]; ext_zero = zs[i];
            tick();
            n_vec++;
            if (ex_imm !== want[i]) begin
                n_err++; $display("FAIL ext_imm[%0d] got=%h want=%h", i, ex_imm, want[i]);
            end
        end
    endtask

    task automatic test_load_use();
        idle();
        id_valid = 1; c_mem_read = 1; c_reg_write = 1; c_dst_rt = 1; rt = 2; rs = 1; rd = 5;
        tick();
        n_vec++;
        if ({ex_mem_read, ex_dest} !== {1'b1, 3'd2}) begin
            n_err++; $display("FAIL load_in_ex got=%b/%0d want=1/2", ex_mem_read, ex_dest);
        end
        idle();
        id_valid = 1; rs = 2; rt = 6; rd = 7; c_reg_write = 1; pc4_in = 16'h0044;
        #1;
        n_vec++;
        if (stall_out !== 1'b1) begin
            n_err++; $display("FAIL load_use_stall got=%b want=1", stall_out);
        end
        tick();
        n_vec++;
        if ({ex_valid, ex_reg_write, ex_mem_read, stall_out} !== 4'b0000) begin
            n_err++; $display("FAIL load_use_bubble got=%b%b%b stall=%b want=000 stall=0",
                              ex_valid, ex_reg_write, ex_mem_read, stall_out);
        end
        tick();
        n_vec++;
        if ({ex_valid, ex_rs, ex_pc4} !== {1'b1, 3'd2, 16'h0044}) begin
            n_err++; $display("FAIL load_use_resume got=%b/%0d/%h want=1/2/0044",
                              ex_valid, ex_rs, ex_pc4);
        end
        idle();
        id_valid = 1; c_mem_read = 1; c_dst_rt = 1; rt = 0; rs = 1;
        tick();
        idle();
        id_valid = 1; rs = 0; rt = 0;
        #1;
        n_vec++;
        if (stall_out !== 1'b0) begin
            n_err++; $display("FAIL zero_dest_stall got=%b want=0", stall_out);
        end
        tick();
        n_vec++;
        if (ex_valid !== 1'b1) begin
            n_err++; $display("FAIL zero_dest_load got=%b want=1", ex_valid);
        end
    endtask

    task automatic test_hold_flush();
        logic [78:0] snap;
        idle();
        id_valid = 1; rs = 3; rt = 4; rd = 6; funct = 5; imm = 8'h9A; pc4_in = 16'h1000;
        c_reg_write = 1; c_mem_read = 1; c_dst_rt = 1;
        tick();
        snap = dut_vec();
        for (int i = 0; i < 3; i++) begin
            ex_hold = 1; id_valid = 1;
            rs = 3'($urandom); rt = 3'($urandom); pc4_in = 16'($urandom);
            imm = 8'($urandom); flush = 1'($urandom);
            tick();
            n_vec++;
            if (dut_vec() !== snap) begin
                n_err++; $display("FAIL hold_stable[%0d] got=%h want=%h", i, dut_vec(), snap);
            end
        end
        idle();
        id_valid = 1; c_reg_write = 1; c_mem_read = 1; rs = 1; rt = 1; rd = 1; flush = 1;
        tick();
        n_vec++;
        if ({ex_valid, ex_reg_write, ex_mem_read} !== 3'b000) begin
            n_err++; $display("FAIL flush_bubble got=%b%b%b want=000",
                              ex_valid, ex_reg_write, ex_mem_read);
        end
    endtask

    task automatic test_reset_mid_stall();
        idle();
        wb_we = 1; wb_addr = 4; wb_data = 16'hA5A5;
        tick();
        idle();
        id_valid = 1; c_mem_read = 1; c_reg_write = 1; c_dst_rt = 1; rt = 4; rs = 1;
        tick();
        idle();
        id_valid = 1; rs = 4; ex_hold = 1;
        tick();
        n_vec++;
        if ({stall_out, ex_valid, ex_mem_read} !== 3'b111) begin
            n_err++; $display("FAIL hold_with_stall got=%b%b%b want=111",
                              stall_out, ex_valid, ex_mem_read);
        end
        reset_n = 0;
        tick();
        n_vec++;
        if ({dut_vec(), stall_out} !== 80'd0) begin
            n_err++; $display("FAIL reset_mid_stall got=%h stall=%b want=0 stall=0",
                              dut_vec(), stall_out);
        end
        idle();
        id_valid = 1; rs = 4;
        tick();
        n_vec++;
        if ({ex_valid, ex_rdata1} !== {1'b1, 16'h0000}) begin
            n_err++; $display("FAIL rf_cleared got=%b/%h want=1/0000", ex_valid, ex_rdata1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset_n     = ($urandom_range(0, 39) != 0);
            id_valid    = ($urandom_range(0, 4) != 0);
            rs          = 3'($urandom); rt = 3'($urandom); rd = 3'($urandom);
            funct       = 3'($urandom); imm = 8'($urandom); ext_zero = 1'($urandom);
            pc4_in      = 16'($urandom);
            c_reg_write = 1'($urandom);
            c_mem_read  = ($urandom_range(0, 9) < 3);
            c_dst_rt    = 1'($urandom);
            wb_we       = 1'($urandom);
            wb_addr     = 3'($urandom); wb_data = 16'($urandom);
            ex_hold     = ($urandom_range(0, 5) == 0);
            flush       = ($urandom_range(0, 7) == 0);
            #1;
            n_vec++;
            if (stall_out !== m_stall()) begin
                n_err++; $display("FAIL rand_stall[%0d] got=%b want=%b", i, stall_out, m_stall());
            end
            tick();
            n_vec++;
            if (dut_vec() !== m_vec()) begin
                n_err++; $display("FAIL rand_ex[%0d] got=%h want=%h", i, dut_vec(), m_vec());
            end
        end
    endtask

    initial begin
        idle();
        for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
        m_bubble();
        @(posedge clock);
        #1;
        test_reset();
        test_bypass();
        test_extension();
        test_load_use();
        test_hold_flush();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
